// File: rtl/si5341_cfg_pkg.sv
// si5341_cfg_pkg: shared definitions for the Si5341 configuration sequencer.
//   state_e     one-hot sequencer states
//   PAGE_REG    Si5341 page-select register address
//   DELAY_MARK  page value that marks a timed-delay table entry
//   *_MSB/_LSB  field positions inside a 24-bit table entry {page, reg, data}
//   cnt_width   width of a counter able to reach max(a, b) without wrapping
package si5341_cfg_pkg;

  typedef enum logic [8:0] {
    ST_IDLE   = 9'b0_0000_0001,
    ST_FETCH  = 9'b0_0000_0010,
    ST_DECODE = 9'b0_0000_0100,
    ST_XFER   = 9'b0_0000_1000,
    ST_GAP    = 9'b0_0001_0000,
    ST_DELAY  = 9'b0_0010_0000,
    ST_NEXT   = 9'b0_0100_0000,
    ST_DONE   = 9'b0_1000_0000,
    ST_ERR    = 9'b1_0000_0000
  } state_e;

  localparam logic [7:0] PAGE_REG   = 8'h01;
  localparam logic [7:0] DELAY_MARK = 8'hFF;

  localparam int unsigned PAGE_MSB = 23;
  localparam int unsigned PAGE_LSB = 16;
  localparam int unsigned REG_MSB  = 15;
  localparam int unsigned REG_LSB  = 8;
  localparam int unsigned DATA_MSB = 7;
  localparam int unsigned DATA_LSB = 0;

  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/si5341_cfg_seq_if.sv
// si5341_cfg_seq_if: byte-write handshake towards i2c_ctrl.
//   wr_req   held high by the master for a whole 3-byte transaction
//   wr_data  byte currently presented to i2c_ctrl
//   wr_done  one-cycle pulse from i2c_ctrl per accepted byte
interface si5341_cfg_seq_if;
  logic       wr_req;
  logic [7:0] wr_data;
  logic       wr_done;

  modport master (output wr_req, output wr_data, input wr_done);
  modport slave  (input wr_req, input wr_data, output wr_done);
endinterface

// File: rtl/si5341_cfg_seq_wr3.sv
// i2c_wr3_seq: issues one {dev, reg, data} write through the i2c_ctrl handshake.
//   clk, rst_n       clock, asynchronous active-low reset
//   go_i             starts a transaction (ignored while one is in progress)
//   dev_i/reg_i/data_i  the three bytes, captured on go_i
//   bus              handshake master (wr_req, wr_data out; wr_done in)
//   xfer_done_o      combinational, high in the cycle the 3rd wr_done is taken
//   xfer_timeout_o   combinational, high in the cycle the byte timeout fires
module i2c_wr3_seq #(
  parameter int unsigned TIMEOUT_CYC = 100_000,
  parameter int unsigned CW          = 25
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    go_i,
  input  logic [7:0]              dev_i,
  input  logic [7:0]              reg_i,
  input  logic [7:0]              data_i,
  si5341_cfg_seq_if.master        bus,
  output logic                    xfer_done_o,
  output logic                    xfer_timeout_o
);

  logic          busy_q, busy_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    wdat_q, wdat_d;
  logic [7:0]    reg_q, reg_d;
  logic [7:0]    dat_q, dat_d;
  logic [CW-1:0] tcnt_q, tcnt_d;

  always_comb begin
    busy_d         = busy_q;
    idx_d          = idx_q;
    wdat_d         = wdat_q;
    reg_d          = reg_q;
    dat_d          = dat_q;
    tcnt_d         = tcnt_q;
    xfer_done_o    = 1'b0;
    xfer_timeout_o = 1'b0;
    if (!busy_q) begin
      if (go_i) begin
        busy_d = 1'b1;
        idx_d  = '0;
        wdat_d = dev_i;
        reg_d  = reg_i;
        dat_d  = data_i;
        tcnt_d = '0;
      end
    end else if (bus.wr_done) begin
      // An acknowledge in the same cycle as the timeout still counts.
      tcnt_d = '0;
      if (idx_q == 2'd2) begin
        busy_d      = 1'b0;
        idx_d       = '0;
        xfer_done_o = 1'b1;
      end else begin
        idx_d  = idx_q + 2'd1;
        wdat_d = (idx_q == 2'd0) ? reg_q : dat_q;
      end
    end else if (tcnt_q == CW'(TIMEOUT_CYC)) begin
      busy_d         = 1'b0;
      idx_d          = '0;
      xfer_timeout_o = 1'b1;
    end else begin
      tcnt_d = tcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      idx_q  <= '0;
      wdat_q <= '0;
      reg_q  <= '0;
      dat_q  <= '0;
      tcnt_q <= '0;
    end else begin
      busy_q <= busy_d;
      idx_q  <= idx_d;
      wdat_q <= wdat_d;
      reg_q  <= reg_d;
      dat_q  <= dat_d;
      tcnt_q <= tcnt_d;
    end
  end

  assign bus.wr_req  = busy_q;
  assign bus.wr_data = wdat_q;

endmodule

// File: rtl/si5341_cfg_seq.sv
// si5341_cfg_seq: walks a register table and writes it to the Si5341A via i2c_ctrl,
// inserting page-select writes on page changes and honouring delay entries.
//   clk, rst_n   clock, asynchronous active-low reset
//   start        one-cycle pulse; accepted only in IDLE/DONE/ERR
//   rom_addr     table index; rom_data {page, reg, data} one cycle later
//   i2c          handshake master towards i2c_ctrl
//   cfg_busy     high while sequencing
//   cfg_done     high after the last entry is written, until the next start
//   cfg_err      high after a byte timeout, until the next start
//   cfg_idx      entry currently being processed
module si5341_cfg_seq
  import si5341_cfg_pkg::*;
#(
  parameter logic [7:0]  DEV_ADDR    = 8'hE8,
  parameter int unsigned ROM_AW      = 9,
  parameter int unsigned NUM_ENTRIES = 400,
  parameter int unsigned DELAY_CYC   = 15_000_000,
  parameter int unsigned GAP_CYC     = 200,
  parameter int unsigned TIMEOUT_CYC = 100_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [23:0]       rom_data,
  si5341_cfg_seq_if.master  i2c,
  output logic              cfg_busy,
  output logic              cfg_done,
  output logic              cfg_err,
  output logic [ROM_AW-1:0] cfg_idx
);

  localparam int unsigned CW = cnt_width(DELAY_CYC, TIMEOUT_CYC);

  state_e            state_q, state_d;
  logic [ROM_AW-1:0] idx_q, idx_d;
  logic [23:0]       entry_q, entry_d;
  logic [7:0]        cur_page_q, cur_page_d;
  logic              page_valid_q, page_valid_d;
  logic              is_page_q, is_page_d;
  logic              fetch_ph_q, fetch_ph_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic       go;
  logic [7:0] x_reg, x_data;
  logic       xfer_done, xfer_timeout;

  logic [7:0] ent_page, ent_reg, ent_data;
  assign ent_page = entry_q[PAGE_MSB:PAGE_LSB];
  assign ent_reg  = entry_q[REG_MSB:REG_LSB];
  assign ent_data = entry_q[DATA_MSB:DATA_LSB];

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    entry_d      = entry_q;
    cur_page_d   = cur_page_q;
    page_valid_d = page_valid_q;
    is_page_d    = is_page_q;
    fetch_ph_d   = fetch_ph_q;
    cnt_d        = cnt_q;
    go           = 1'b0;
    x_reg        = ent_reg;
    x_data       = ent_data;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          idx_d        = '0;
          page_valid_d = 1'b0;
          fetch_ph_d   = 1'b0;
          state_d      = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // The ROM registers the new address at the end of the first FETCH
        // cycle, so the entry is captured at the end of the second.
        if (!fetch_ph_q) begin
          fetch_ph_d = 1'b1;
        end else begin
          fetch_ph_d = 1'b0;
          entry_d    = rom_data;
          state_d    = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (ent_page == DELAY_MARK) begin
          cnt_d   = '0;
          state_d = ST_DELAY;
        end else begin
          go      = 1'b1;
          state_d = ST_XFER;
          if (!page_valid_q || (ent_page != cur_page_q)) begin
            is_page_d = 1'b1;
            x_reg     = PAGE_REG;
            x_data    = ent_page;
          end else begin
            is_page_d = 1'b0;
          end
        end
      end
      ST_XFER: begin
        if (xfer_timeout) begin
          state_d = ST_ERR;
        end else if (xfer_done) begin
          cnt_d   = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (cnt_q == CW'(GAP_CYC - 1)) begin
          if (is_page_q) begin
            // Same entry is decoded again and now takes the register path.
            cur_page_d   = ent_page;
            page_valid_d = 1'b1;
            state_d      = ST_DECODE;
          end else begin
            state_d = ST_NEXT;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DELAY: begin
        if (cnt_q == CW'(DELAY_CYC - 1)) begin
          state_d = ST_NEXT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_NEXT: begin
        if (idx_q == ROM_AW'(NUM_ENTRIES - 1)) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      entry_q      <= '0;
      cur_page_q   <= '0;
      page_valid_q <= 1'b0;
      is_page_q    <= 1'b0;
      fetch_ph_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      entry_q      <= entry_d;
      cur_page_q   <= cur_page_d;
      page_valid_q <= page_valid_d;
      is_page_q    <= is_page_d;
      fetch_ph_q   <= fetch_ph_d;
      cnt_q        <= cnt_d;
    end
  end

  i2c_wr3_seq #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CW          (CW)
  ) u_wr3 (
    .clk            (clk),
    .rst_n          (rst_n),
    .go_i           (go),
    .dev_i          (DEV_ADDR),
    .reg_i          (x_reg),
    .data_i         (x_data),
    .bus            (i2c),
    .xfer_done_o    (xfer_done),
    .xfer_timeout_o (xfer_timeout)
  );

  assign rom_addr = idx_q;
  assign cfg_idx  = idx_q;
  assign cfg_busy = !(state_q inside {ST_IDLE, ST_DONE, ST_ERR});
  assign cfg_done = (state_q == ST_DONE);
  assign cfg_err  = (state_q == ST_ERR);

endmodule

// File: tb/tb_si5341_cfg_seq.sv
// Bench for si5341_cfg_seq: a 6-entry table DUT (paging, delay, timeout, reset)
// and a single-entry DUT, each served by an i2c_ctrl model acking bytes after 50 cycles.
module tb_si5341_cfg_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start0, start1;
  logic [8:0]  rom_addr0, rom_addr1, idx0, idx1;
  logic [23:0] rom_data0, rom_data1;
  logic busy0, done0, err0, busy1, done1, err1;
  logic [23:0] tbl0 [8];

  si5341_cfg_seq_if bus0 ();
  si5341_cfg_seq_if bus1 ();

  si5341_cfg_seq #(
    .DEV_ADDR (8'hE8), .ROM_AW (9), .NUM_ENTRIES (6),
    .DELAY_CYC (1000), .GAP_CYC (200), .TIMEOUT_CYC (500)
  ) dut0 (
    .clk (clk), .rst_n (rst_n), .start (start0), .rom_addr (rom_addr0),
    .rom_data (rom_data0), .i2c (bus0), .cfg_busy (busy0), .cfg_done (done0),
    .cfg_err (err0), .cfg_idx (idx0)
  );

  si5341_cfg_seq #(
    .DEV_ADDR (8'hE8), .ROM_AW (9), .NUM_ENTRIES (1),
    .DELAY_CYC (1000), .GAP_CYC (200), .TIMEOUT_CYC (500)
  ) dut1 (
    .clk (clk), .rst_n (rst_n), .start (start1), .rom_addr (rom_addr1),
    .rom_data (rom_data1), .i2c (bus1), .cfg_busy (busy1), .cfg_done (done1),
    .cfg_err (err1), .cfg_idx (idx1)
  );

  always @(posedge clk) rom_data0 <= tbl0[rom_addr0[2:0]];
  always @(posedge clk) rom_data1 <= 24'h010B24;

  // i2c_ctrl model
  logic       req  [2];
  logic [7:0] dat  [2];
  logic       done [2];
  assign req[0] = bus0.wr_req;
  assign req[1] = bus1.wr_req;
  assign dat[0] = bus0.wr_data;
  assign dat[1] = bus1.wr_data;
  assign bus0.wr_done = done[0];
  assign bus1.wr_done = done[1];

  logic        act   [2];
  logic        req_p [2];
  int unsigned bc    [2];
  int unsigned nbytes[2];
  int unsigned ntx   [2];
  logic [7:0]  log0[$];
  logic [7:0]  log1[$];
  int unsigned runs[$];
  int unsigned lowrun = 0, withhold = 0, cyc = 0, t_done = 0, t_fall = 0;
  int unsigned idx_back = 0;
  logic [8:0]  idx_prev = '0;
  logic        busy_prev = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        done[k]  <= 1'b0;
        act[k]   = 1'b0;
        req_p[k] = 1'b0;
        bc[k]    = 0;
      end
      busy_prev = 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        done[k] <= 1'b0;
        if (req[k] && !req_p[k]) begin
          ntx[k]++;
          if (k == 0) begin runs.push_back(lowrun); lowrun = 0; end
        end
        if (k == 0) begin
          if (!req[0]) lowrun++;
          if (done[0]) t_done = cyc;
          if (req_p[0] && !req[0]) t_fall = cyc - 1;
        end
        if (!req[k]) begin
          act[k] = 1'b0;
        end else if (act[k]) begin
          bc[k]++;
          if (bc[k] == 50 && !(k == 0 && nbytes[0] == withhold)) begin
            done[k] <= 1'b1;
            act[k]  = 1'b0;
          end
        end else if (!done[k]) begin
          act[k] = 1'b1;
          bc[k]  = 1;
          nbytes[k]++;
          if (k == 0) log0.push_back(dat[0]); else log1.push_back(dat[1]);
        end
        req_p[k] = req[k];
      end
      if (busy0 && busy_prev && (idx0 < idx_prev)) idx_back++;
      busy_prev = busy0;
      idx_prev  = idx0;
      cyc++;
    end
  end

  int unsigned errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start0();
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
  endtask

  logic [7:0] exp0 [21] = '{8'hE8, 8'h01, 8'h00, 8'hE8, 8'h0B, 8'h24, 8'hE8, 8'h0C, 8'h00,
                            8'hE8, 8'h0D, 8'h11, 8'hE8, 8'h01, 8'h05, 8'hE8, 8'h20, 8'hAA,
                            8'hE8, 8'h21, 8'hBB};
  logic [7:0] exp1 [6]  = '{8'hE8, 8'h01, 8'h01, 8'hE8, 8'h0B, 8'h24};

  initial begin
    tbl0[0] = 24'h000B24; tbl0[1] = 24'h000C00; tbl0[2] = 24'hFF0000;
    tbl0[3] = 24'h000D11; tbl0[4] = 24'h0520AA; tbl0[5] = 24'h0521BB;
    tbl0[6] = 24'h0; tbl0[7] = 24'h0;
    for (int k = 0; k < 2; k++) begin nbytes[k] = 0; ntx[k] = 0; end
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // reset values
    chk("rst_wr_req", bus0.wr_req, 0);
    chk("rst_wr_data", bus0.wr_data, 0);
    chk("rst_rom_addr", rom_addr0, 0);
    chk("rst_cfg_idx", idx0, 0);
    chk("rst_flags", {busy0, done0, err0}, 0);

    // single-entry table
    start1 = 1'b1; @(negedge clk); start1 = 1'b0;
    chk("one_busy", busy1, 1);
    for (int i = 0; i < 3000 && !done1; i++) @(negedge clk);
    chk("one_done", done1, 1);
    chk("one_busy_end", busy1, 0);
    chk("one_ntx", ntx[1], 2);
    chk("one_nbytes", log1.size(), 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("one_byte%0d", i), (i < int'(log1.size())) ? 32'(log1[i]) : 32'hFFFF_FFFF, 32'(exp1[i]));

    // full table, start pulsed while busy on entry 2
    log0.delete(); runs.delete(); lowrun = 0; ntx[0] = 0;
    pulse_start0();
    for (int i = 0; i < 5000 && idx0 != 9'd2; i++) @(negedge clk);
    pulse_start0();
    chk("busy_start_idx", idx0, 2);
    chk("busy_start_busy", busy0, 1);
    for (int i = 0; i < 20000 && !done0; i++) @(negedge clk);
    chk("run_done", done0, 1);
    chk("run_busy_end", busy0, 0);
    chk("run_err", err0, 0);
    chk("run_last_idx", idx0, 5);
    chk("run_ntx", ntx[0], 7);
    chk("run_nbytes", log0.size(), 21);
    for (int i = 0; i < 21; i++)
      chk($sformatf("run_byte%0d", i), (i < int'(log0.size())) ? 32'(log0[i]) : 32'hFFFF_FFFF, 32'(exp0[i]));
    chk("delay_gap_ge_1000", (runs.size() > 3) && (runs[3] >= 1000), 1);
    chk("idx_never_back", idx_back, 0);

    // timeout on the 2nd byte of the first transaction
    log0.delete(); nbytes[0] = 0; withhold = 2;
    pulse_start0();
    chk("restart_done_clr", done0, 0);
    for (int i = 0; i < 5000 && !err0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("to_err", err0, 1);
    chk("to_busy", busy0, 0);
    chk("to_wr_req", bus0.wr_req, 0);
    chk("to_latency", t_fall - t_done, 501);
    chk("to_nbytes", log0.size(), 2);
    withhold = 0;
    pulse_start0();
    chk("to_restart_err", err0, 0);
    chk("to_restart_addr", rom_addr0, 0);
    chk("to_restart_busy", busy0, 1);

    // asynchronous reset during the data byte of entry 3
    for (int i = 0; i < 20000 && !(idx0 == 9'd3 && bus0.wr_req && bus0.wr_data == 8'h11); i++)
      @(negedge clk);
    chk("e3_data_byte", bus0.wr_data, 8'h11);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wr_req", bus0.wr_req, 0);
    chk("arst_busy", busy0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ntx[0] = 0;
    repeat (300) @(negedge clk);
    chk("post_rst_quiet", ntx[0], 0);
    chk("post_rst_flags", {busy0, done0, err0}, 0);
    log0.delete();
    pulse_start0();
    for (int i = 0; i < 2000 && log0.size() < 3; i++) @(negedge clk);
    chk("post_rst_b0", (log0.size() > 0) ? 32'(log0[0]) : 32'hFFFF_FFFF, 32'hE8);
    chk("post_rst_b1", (log0.size() > 1) ? 32'(log0[1]) : 32'hFFFF_FFFF, 32'h01);
    chk("post_rst_b2", (log0.size() > 2) ? 32'(log0[2]) : 32'hFFFF_FFFF, 32'h00);
    for (int i = 0; i < 20000 && !done0; i++) @(negedge clk);
    chk("post_rst_done", done0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
